// File: rtl/sdram_frame_arbiter.sv
// Burst scheduler between the camera write FIFO, the VGA read FIFO and the SDRAM
// command port, with triple-buffered frame banks swapped on frame boundaries.
module sdram_frame_arbiter #(
  parameter int ADDR_W        = 22,
  parameter int LVL_W         = 10,
  parameter int FRAME_WORDS   = 307200,
  parameter int FRAME_STRIDE  = 524288,
  parameter int BURST_LEN     = 256,
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int RD_URGENT     = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic [LVL_W-1:0]  wr_fifo_usedw,
  input  logic [LVL_W-1:0]  rd_fifo_usedw,
  input  logic              frame_valid,
  input  logic              vga_framesync,
  output logic              cmd_req,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LVL_W-1:0]  cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic              frame_drop,
  output logic [1:0]        dbg_state
);

  localparam int                PTR_W    = $clog2(FRAME_WORDS + 1);
  localparam logic [PTR_W-1:0]  FW_P     = PTR_W'(FRAME_WORDS);
  localparam logic [PTR_W-1:0]  BL_P     = PTR_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  BL_L     = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  URG_L    = LVL_W'(RD_URGENT);
  localparam logic [LVL_W-1:0]  ROOM_L   = LVL_W'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(FRAME_STRIDE);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, BUSY = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
  logic [LVL_W-1:0]   cmd_len_q, cmd_len_d;
  logic [1:0]         wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]         complete_bank_q, complete_bank_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               fv_q, vs_q, cam_pend_q, cam_pend_d, vga_pend_q, vga_pend_d;
  logic               frame_drop_q, frame_drop_d;

  logic               cam_edge, vga_edge, burst_done, in_flight;
  logic               cam_event, vga_event, cam_hold, vga_hold, cam_go, vga_go;
  logic               pick_rd_urgent, pick_wr, pick_rd_fill, pick_any, pick_is_wr;
  logic [PTR_W-1:0]   sel_ptr, remain, wr_ptr_adv, rd_ptr_adv;
  logic [1:0]         sel_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = REQ;
      REQ:     if (cmd_ack)  state_d = BUSY;
      BUSY:    if (cmd_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_req    = (state_q == REQ);
    cmd_wr     = cmd_wr_q;
    cmd_addr   = cmd_addr_q;
    cmd_len    = cmd_len_q;
    wr_bank    = wr_bank_q;
    rd_bank    = rd_bank_q;
    frame_drop = frame_drop_q;
    dbg_state  = state_q;
  end

  // Burst selection; a frame edge seen in IDLE moves a pointer, so picking waits a cycle.
  always_comb begin
    pick_rd_urgent = (rd_fifo_usedw < URG_L) && (rd_ptr_q < FW_P);
    pick_wr        = (wr_fifo_usedw >= BL_L) && (wr_ptr_q < FW_P);
    pick_rd_fill   = (rd_fifo_usedw <= ROOM_L) && (rd_ptr_q < FW_P);
    pick_is_wr     = !pick_rd_urgent && pick_wr;
    pick_any       = (state_q == IDLE) && init_done && !cam_edge && !vga_edge &&
                     (pick_rd_urgent || pick_wr || pick_rd_fill);
    sel_ptr        = pick_is_wr ? wr_ptr_q : rd_ptr_q;
    sel_bank       = pick_is_wr ? wr_bank_q : rd_bank_q;
    remain         = FW_P - sel_ptr;
    cmd_wr_d       = cmd_wr_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_len_d      = cmd_len_q;
    if (pick_any) begin
      cmd_wr_d   = pick_is_wr;
      cmd_addr_d = ADDR_W'(sel_bank) * STRIDE_A + ADDR_W'(sel_ptr);
      cmd_len_d  = (remain >= BL_P) ? BL_L : LVL_W'(remain);
    end
  end

  // A frame edge on the path of the in-flight burst waits for cmd_done; a VGA edge
  // also waits behind a held camera edge so the swap is always seen first.
  always_comb begin
    cam_edge   = frame_valid & ~fv_q;
    vga_edge   = vga_framesync & ~vs_q;
    burst_done = (state_q == BUSY) && cmd_done;
    in_flight  = (state_q != IDLE) && !burst_done;
    cam_event  = cam_edge | cam_pend_q;
    vga_event  = vga_edge | vga_pend_q;
    cam_hold   = in_flight & cmd_wr_q;
    cam_pend_d = cam_event & cam_hold;
    vga_hold   = in_flight & (~cmd_wr_q | cam_pend_d);
    vga_pend_d = vga_event & vga_hold;
    cam_go     = cam_event & ~cam_hold;
    vga_go     = vga_event & ~vga_hold;

    wr_ptr_adv = wr_ptr_q;
    rd_ptr_adv = rd_ptr_q;
    if (burst_done && cmd_wr_q)  wr_ptr_adv = wr_ptr_q + PTR_W'(cmd_len_q);
    if (burst_done && !cmd_wr_q) rd_ptr_adv = rd_ptr_q + PTR_W'(cmd_len_q);

    wr_ptr_d        = wr_ptr_adv;
    rd_ptr_d        = rd_ptr_adv;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    complete_bank_d = complete_bank_q;
    frame_drop_d    = 1'b0;
    if (cam_go) begin
      if (wr_ptr_adv == FW_P) begin
        complete_bank_d = wr_bank_q;
        wr_bank_d       = 2'd3 - wr_bank_q - rd_bank_q;
      end else begin
        frame_drop_d = 1'b1;
      end
      wr_ptr_d = '0;
    end
    if (vga_go) begin
      rd_bank_d = complete_bank_d;
      rd_ptr_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_q        <= 1'b0;
      cmd_addr_q      <= '0;
      cmd_len_q       <= '0;
      wr_bank_q       <= 2'd0;
      rd_bank_q       <= 2'd2;
      complete_bank_q <= 2'd2;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fv_q            <= 1'b0;
      vs_q            <= 1'b0;
      cam_pend_q      <= 1'b0;
      vga_pend_q      <= 1'b0;
      frame_drop_q    <= 1'b0;
    end else begin
      cmd_wr_q        <= cmd_wr_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_len_q       <= cmd_len_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      complete_bank_q <= complete_bank_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fv_q            <= frame_valid;
      vs_q            <= vga_framesync;
      cam_pend_q      <= cam_pend_d;
      vga_pend_q      <= vga_pend_d;
      frame_drop_q    <= frame_drop_d;
    end
  end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter: expected commands go into a queue and a
// negedge monitor compares each accepted command; bank/drop state is checked directly.
module tb_sdram_frame_arbiter;

  localparam int ADDR_W = 22;
  localparam int LVL_W  = 10;
  localparam int CW     = 1 + ADDR_W + LVL_W;
  localparam int BANK1  = 524288;
  localparam int BANK2  = 1048576;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_done;
  logic [LVL_W-1:0]  wr_fifo_usedw;
  logic [LVL_W-1:0]  rd_fifo_usedw;
  logic              frame_valid;
  logic              vga_framesync;
  logic              cmd_req;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LVL_W-1:0]  cmd_len;
  logic              cmd_ack;
  logic              cmd_done;
  logic [1:0]        wr_bank;
  logic [1:0]        rd_bank;
  logic              frame_drop;
  logic [1:0]        dbg_state;

  logic [CW-1:0]     exp_q[$];
  logic [CW-1:0]     exp_c;
  int                n_cmp = 0;
  int                n_bad = 0;
  int                drop_cnt = 0;
  bit                req_seen = 1'b0;

  sdram_frame_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_fifo_usedw(wr_fifo_usedw), .rd_fifo_usedw(rd_fifo_usedw),
    .frame_valid(frame_valid), .vga_framesync(vga_framesync),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ack(cmd_ack), .cmd_done(cmd_done),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_drop(frame_drop),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit hit, state=%0d, expected run to finish", dbg_state);
    $fatal(1, "watchdog expired");
  end

  // Monitor: every accepted command is checked against the scoreboard queue
  always @(negedge clk) begin
    if (rst_n && cmd_req && cmd_ack) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL cmd_unexpected: got wr=%0d addr=%0d len=%0d, expected no command",
                 cmd_wr, cmd_addr, cmd_len);
      end else begin
        exp_c = exp_q.pop_front();
        if ({cmd_wr, cmd_addr, cmd_len} !== exp_c) begin
          n_bad++;
          $display("FAIL cmd: got wr=%0d addr=%0d len=%0d, expected wr=%0d addr=%0d len=%0d",
                   cmd_wr, cmd_addr, cmd_len, exp_c[CW-1], exp_c[CW-2:LVL_W], exp_c[LVL_W-1:0]);
        end
      end
    end
    if (rst_n && frame_drop) drop_cnt++;
    if (cmd_req) req_seen = 1'b1;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!cmd_req && n < 64) begin
      step();
      n++;
    end
    if (!cmd_req) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: cmd_req=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic expect_burst(input logic w, input logic [ADDR_W-1:0] a,
                              input logic [LVL_W-1:0] l);
    exp_q.push_back({w, a, l});
    wait_req();
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0; frame_valid = 1'b0; vga_framesync = 1'b0;
    cmd_ack = 1'b0; cmd_done = 1'b0;
    wr_fifo_usedw = 10'd512; rd_fifo_usedw = 10'd1000;
    steps(3);
    check("rst_cmd_req",    32'(cmd_req),    32'd0);
    check("rst_cmd_wr",     32'(cmd_wr),     32'd0);
    check("rst_cmd_addr",   32'(cmd_addr),   32'd0);
    check("rst_cmd_len",    32'(cmd_len),    32'd0);
    check("rst_wr_bank",    32'(wr_bank),    32'd0);
    check("rst_rd_bank",    32'(rd_bank),    32'd2);
    check("rst_frame_drop", 32'(frame_drop), 32'd0);
    rst_n = 1'b1;

    // 1: no command before init_done, then a full write burst at bank 0
    steps(10);
    check("no_req_before_init", 32'(req_seen), 32'd0);
    init_done = 1'b1;
    expect_burst(1'b1, ADDR_W'(0), LVL_W'(256));

    // 2: urgent read beats a ready write
    rd_fifo_usedw = 10'd100; wr_fifo_usedw = 10'd300;
    expect_burst(1'b0, ADDR_W'(BANK2), LVL_W'(256));
    rd_fifo_usedw = 10'd1000; wr_fifo_usedw = 10'd512;

    // 3: finish the camera frame, pointer stops, then a clean swap
    for (int i = 1; i < 1200; i++) expect_burst(1'b1, ADDR_W'(i * 256), LVL_W'(256));
    steps(4);
    check("wr_ptr_stops", 32'(cmd_req), 32'd0);
    wr_fifo_usedw = 10'd0;
    frame_valid = 1'b1;
    steps(2);
    check("t3_wr_bank", 32'(wr_bank), 32'd1);
    check("t3_no_drop", 32'(drop_cnt), 32'd0);
    frame_valid = 1'b0;

    // 4: VGA picks up bank 0, next camera frame in bank 1 swaps to bank 2
    vga_framesync = 1'b1;
    steps(2);
    check("t4_rd_bank", 32'(rd_bank), 32'd0);
    vga_framesync = 1'b0;
    wr_fifo_usedw = 10'd512;
    for (int i = 0; i < 1200; i++) expect_burst(1'b1, ADDR_W'(BANK1 + i * 256), LVL_W'(256));
    wr_fifo_usedw = 10'd0;
    steps(2);
    frame_valid = 1'b1;
    steps(2);
    check("t4_wr_bank", 32'(wr_bank), 32'd2);
    frame_valid = 1'b0;
    vga_framesync = 1'b1;
    steps(2);
    check("t4_rd_bank_complete", 32'(rd_bank), 32'd1);
    vga_framesync = 1'b0;
    check("t4_no_drop", 32'(drop_cnt), 32'd0);

    // 5: camera restarts a partial frame -> drop, same bank, pointer back to 0
    wr_fifo_usedw = 10'd512;
    for (int i = 0; i < 200; i++) expect_burst(1'b1, ADDR_W'(BANK2 + i * 256), LVL_W'(256));
    wr_fifo_usedw = 10'd0;
    steps(2);
    frame_valid = 1'b1;
    steps(3);
    check("t5_drop_pulse", 32'(drop_cnt), 32'd1);
    check("t5_wr_bank",    32'(wr_bank),  32'd2);
    check("t5_rd_bank",    32'(rd_bank),  32'd1);
    frame_valid = 1'b0;
    wr_fifo_usedw = 10'd512;
    expect_burst(1'b1, ADDR_W'(BANK2), LVL_W'(256));

    // 6: both edges during the last write burst; swap lands on cmd_done
    for (int i = 1; i < 1199; i++) expect_burst(1'b1, ADDR_W'(BANK2 + i * 256), LVL_W'(256));
    exp_q.push_back({1'b1, ADDR_W'(BANK2 + 306944), LVL_W'(256)});
    wait_req();
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    frame_valid = 1'b1; vga_framesync = 1'b1;
    step();
    check("t6_wr_bank_held", 32'(wr_bank), 32'd2);
    check("t6_rd_bank_held", 32'(rd_bank), 32'd1);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    frame_valid = 1'b0; vga_framesync = 1'b0;
    check("t6_wr_bank_swapped", 32'(wr_bank), 32'd0);
    check("t6_rd_bank_old_wr",  32'(rd_bank), 32'd2);
    check("t6_banks_differ",    32'(wr_bank != rd_bank), 32'd1);
    expect_burst(1'b1, ADDR_W'(0), LVL_W'(256));
    check("t6_no_drop", 32'(drop_cnt), 32'd1);

    // 7: reset mid-burst, stray cmd_done afterwards is ignored
    exp_q.push_back({1'b1, ADDR_W'(256), LVL_W'(256)});
    wait_req();
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    rst_n = 1'b0;
    step();
    check("t7_rst_cmd_req", 32'(cmd_req), 32'd0);
    check("t7_rst_wr_bank", 32'(wr_bank), 32'd0);
    check("t7_rst_rd_bank", 32'(rd_bank), 32'd2);
    check("t7_rst_addr",    32'(cmd_addr), 32'd0);
    rst_n = 1'b1;
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    expect_burst(1'b1, ADDR_W'(0), LVL_W'(256));
    expect_burst(1'b1, ADDR_W'(256), LVL_W'(256));

    steps(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
